// File: rtl/sd_sector_packer.sv
// sd_sector_packer
//   Pops 32-bit words from the ADC sample FIFO and streams 512-byte SD
//   sectors byte-by-byte over a valid/ready handshake:
//     4-byte header {HEADER_MAGIC, seq[23:16], seq[15:8], seq[7:0]}
//     WORDS_PER_SECTOR payload words, each sent MSB first.
//   Optional build macro SD_SECTOR_CHECKSUM_EN: the last payload slot
//   carries {16'h0000, sum16} (mod-2^16 sum of all preceding payload
//   bytes) instead of FIFO data, so one fewer word is popped per sector.
//   SEQ_INIT is the reset value of the sector sequence counter (0 in
//   normal use; non-zero values let a sequence wrap be observed quickly).
module sd_sector_packer #(
    parameter int          WORDS_PER_SECTOR = 127,
    parameter logic [7:0]  HEADER_MAGIC     = 8'hA5,
    parameter logic [23:0] SEQ_INIT         = 24'h000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fifo_half_filled,
    input  logic        fifo_empty,
    output logic        fifo_read_enable,
    input  logic [31:0] fifo_data,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        sector_start,
    output logic        sector_done,
    output logic [23:0] sector_seq
);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        FETCH,
        WAIT,
        SEND,
        DONE
    } state_t;

    localparam logic [6:0] LAST_SLOT = 7'(WORDS_PER_SECTOR - 1);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  byte_idx;   // byte position within header or current word
    logic [6:0]  slot_cnt;   // completed payload words in this sector
    logic [31:0] word_q;     // payload word being serialised
    logic [31:0] word_load;  // value captured into word_q in WAIT
    logic        need_pop;   // current slot is sourced from the FIFO
    logic        xfer;       // a byte is accepted this cycle

    // valid is high exactly in HEADER and SEND, so acceptance only needs ready
    assign xfer = ((state == HEADER) || (state == SEND)) && byte_ready;

`ifdef SD_SECTOR_CHECKSUM_EN
    logic [15:0] sum16;
    logic        cks_slot;

    assign cks_slot  = (slot_cnt == LAST_SLOT);
    assign need_pop  = !cks_slot;
    assign word_load = cks_slot ? {16'h0000, sum16} : fifo_data;

    // Running sum of every payload byte handed to the consumer
    always_ff @(posedge clock) begin
        if (reset || state == IDLE) begin
            sum16 <= 16'h0000;
        end else if (state == SEND && xfer) begin
            sum16 <= sum16 + {8'h00, byte_data};
        end
    end
`else
    assign need_pop  = 1'b1;
    assign word_load = fifo_data;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs; outputs depend only on registered
    // state, so byte_data/byte_valid cannot move while a byte is stalled
    always_comb begin
        state_nxt        = state;
        fifo_read_enable = 1'b0;
        byte_valid       = 1'b0;
        byte_data        = 8'h00;
        sector_done      = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_half_filled) begin
                    state_nxt = HEADER;
                end
            end
            HEADER: begin
                byte_valid = 1'b1;
                case (byte_idx)
                    2'd0:    byte_data = HEADER_MAGIC;
                    2'd1:    byte_data = sector_seq[23:16];
                    2'd2:    byte_data = sector_seq[15:8];
                    default: byte_data = sector_seq[7:0];
                endcase
                if (byte_ready && byte_idx == 2'd3) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                // Stall here while the FIFO is empty; the checksum slot never pops
                if (!need_pop) begin
                    state_nxt = WAIT;
                end else if (!fifo_empty) begin
                    fifo_read_enable = 1'b1;
                    state_nxt        = WAIT;
                end
            end
            WAIT: begin
                // FIFO Q is registered: data lands this cycle
                state_nxt = SEND;
            end
            SEND: begin
                byte_valid = 1'b1;
                case (byte_idx)
                    2'd0:    byte_data = word_q[31:24];
                    2'd1:    byte_data = word_q[23:16];
                    2'd2:    byte_data = word_q[15:8];
                    default: byte_data = word_q[7:0];
                endcase
                if (byte_ready && byte_idx == 2'd3) begin
                    state_nxt = (slot_cnt == LAST_SLOT) ? DONE : FETCH;
                end
            end
            DONE: begin
                sector_done = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Byte position: advances on each accepted byte, wraps 3 -> 0
    always_ff @(posedge clock) begin
        if (reset || state == IDLE) begin
            byte_idx <= 2'd0;
        end else if (xfer) begin
            byte_idx <= byte_idx + 2'd1;
        end
    end

    // Payload slot counter: one count per fully sent word
    always_ff @(posedge clock) begin
        if (reset || state == IDLE) begin
            slot_cnt <= 7'd0;
        end else if (state == SEND && xfer && byte_idx == 2'd3) begin
            slot_cnt <= slot_cnt + 7'd1;
        end
    end

    // Word capture one cycle after the FIFO read pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            word_q <= 32'h0000_0000;
        end else if (state == WAIT) begin
            word_q <= word_load;
        end
    end

    // Sequence number advances as sector_done pulses; wraps naturally
    always_ff @(posedge clock) begin
        if (reset) begin
            sector_seq <= SEQ_INIT;
        end else if (state == DONE) begin
            sector_seq <= sector_seq + 24'd1;
        end
    end

    // sector_start lines up with the first header byte's first valid cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            sector_start <= 1'b0;
        end else begin
            sector_start <= (state == IDLE) && fifo_half_filled;
        end
    end

endmodule
